ssg_write_sequencer: RTL

- Queues SSG register write requests from internal sources (boot-time mixer init, sound driver, test sequencer) and replays each one onto the SSG I/O bus.
- Each request becomes two bus write cycles: register number to PORT_ADDR (latch), then data to PORT_ADDR+1.
- Sits between internal requesters and the ssg bus mux, and only starts a bus cycle while the CPU is not driving the bus.

---
 rtl/ssg_write_sequencer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/ssg_write_sequencer.sv
// Buffers SSG register write requests in a small FIFO and replays each as a
// latch write (PORT_ADDR) followed by a data write (PORT_ADDR+1) on the I/O bus.
module ssg_write_sequencer #(
  parameter int          DEPTH_LOG2    = 2,
  parameter int          STROBE_CYCLES = 6,
  parameter int          GAP_CYCLES    = 1,
  parameter logic [15:0] PORT_ADDR     = 16'h00A0
) (
  input  logic                  reset_n,
  input  logic                  clk,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            req_reg,
  input  logic [7:0]            req_data,
  input  logic                  bus_free,
  output logic                  busy,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic                  iorq_n,
  output logic                  wr_n,
  output logic [15:0]           address,
  output logic [7:0]            wdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int MAXC  = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
  localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CNT_W-1:0]    STROBE_LD = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0]    GAP_LD    = CNT_W'(GAP_CYCLES - 1);
  localparam logic [DEPTH_LOG2:0] FULL_LVL  = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [15:0]         DATA_ADDR = PORT_ADDR + 16'd1;

  typedef enum logic [2:0] {
    IDLE, ADDR_STROBE, ADDR_GAP, DATA_STROBE, DATA_GAP
  } state_t;

  state_t                state, state_nx;
  logic [CNT_W-1:0]      cnt, cnt_nx;
  logic [11:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [7:0]            cur_data;
  logic                  push, pop;
  logic                  iorq_nx, wr_nx;
  logic [15:0]           addr_nx;
  logic [7:0]            wdata_nx;

  // Ready comes from the registered level only, so a pop never frees a slot
  // for a push in the same cycle.
  assign req_ready = (fifo_level != FULL_LVL);
  assign push      = req_valid && req_ready;
  assign busy      = (state != IDLE) || (fifo_level != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {req_reg, req_data};
    if (pop)  cur_data    <= mem[rd_ptr][7:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      state      <= IDLE;
      cnt        <= '0;
      iorq_n     <= 1'b1;
      wr_n       <= 1'b1;
      address    <= '0;
      wdata      <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      state   <= state_nx;
      cnt     <= cnt_nx;
      iorq_n  <= iorq_nx;
      wr_n    <= wr_nx;
      address <= addr_nx;
      wdata   <= wdata_nx;
    end
  end

  // Counter is loaded with N-1 on phase entry; a phase ends when it reads zero.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    iorq_nx  = iorq_n;
    wr_nx    = wr_n;
    addr_nx  = address;
    wdata_nx = wdata;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        if ((fifo_level != '0) && bus_free) begin
          pop      = 1'b1;
          state_nx = ADDR_STROBE;
          cnt_nx   = STROBE_LD;
          iorq_nx  = 1'b0;
          wr_nx    = 1'b0;
          addr_nx  = PORT_ADDR;
          wdata_nx = {4'd0, mem[rd_ptr][11:8]};
        end
      end
      ADDR_STROBE, DATA_STROBE: begin
        if (cnt == '0) begin
          state_nx = (state == ADDR_STROBE) ? ADDR_GAP : DATA_GAP;
          cnt_nx   = GAP_LD;
          iorq_nx  = 1'b1;
          wr_nx    = 1'b1;
          addr_nx  = '0;
          wdata_nx = '0;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      ADDR_GAP: begin
        if (cnt != '0) begin
          cnt_nx = cnt - 1'b1;
        end else if (bus_free) begin
          state_nx = DATA_STROBE;
          cnt_nx   = STROBE_LD;
          iorq_nx  = 1'b0;
          wr_nx    = 1'b0;
          addr_nx  = DATA_ADDR;
          wdata_nx = cur_data;
        end
      end
      DATA_GAP: begin
        if (cnt == '0) state_nx = IDLE;
        else           cnt_nx   = cnt - 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
